sram_burst_controller: RTL

- Responder end of the cache-to-SRAM request interface. It accepts single-word write requests and paired-word (64-bit) read-fill requests, and returns `ready` plus 64-bit read data.
- Translates each request into a sequence of timed accesses on the external 16-bit asynchronous SRAM (256K x 16).
- Sits between the cache controller in the MEM stage and the board SRAM pins. Its `ready` drives the pipeline freeze.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_dq_buf.sv | 34 +++
 rtl/sram_burst_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM burst controller slice.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned SRAM_DW = 16;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned WORD_AW = 17;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_dq_buf.sv
// Tri-state SRAM data bus driver with a registered drive enable, plus the
// 64-bit read-fill capture register.
module sram_dq_buf
  import sram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               drive_next,
  input  logic [SRAM_DW-1:0] dout,
  input  logic               cap_en,
  input  logic [1:0]         cap_sel,
  input  logic               clr,
  output logic [63:0]        rdata,
  inout  wire  [SRAM_DW-1:0] dq
);

  logic drive_q;

  // Drive enable is registered so the bus turns on/off cleanly on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drive_q <= 1'b0;
    else     drive_q <= drive_next;
  end

  assign dq = drive_q ? dout : {SRAM_DW{1'bz}};

  // Capture one halfword of the read fill into its slot; clr zeroes the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata <= '0;
    else if (clr)    rdata <= '0;
    else if (cap_en) rdata[{cap_sel, 4'b0000} +: SRAM_DW] <= dq;
  end

endmodule

// File: rtl/sram_burst_controller.sv
// Cache-side responder translating single-word writes and 64-bit read fills
// into timed accesses on a 256K x 16 asynchronous SRAM.
// Optional: define SRAM_ADDR_CHECK_EN to reject out-of-range requests
// (IDLE -> DONE with addr_err, no SRAM activity, read data forced to 0).
module sram_burst_controller
  import sram_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [63:0]        rdata,
  output logic               ready,
  output logic               addr_err,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int unsigned ACC_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n;
  logic [1:0]         hw, hw_n;
  logic [WORD_AW-1:0] word_q, word_n;
  logic [31:0]        wdata_q, wdata_n;
  logic               acc_last;
  logic               cap_en;
  logic               clr;
  logic               bad;
  logic               drive_next;
  logic [SRAM_DW-1:0] dout;

  assign acc_last = (acc == ACC_W'(ACCESS_CYCLES - 1));

`ifdef SRAM_ADDR_CHECK_EN
  logic err_q;

  assign bad = (address < BASE_ADDR) || (((address - BASE_ADDR) >> 19) != 32'd0);

  // Remember whether the request just accepted was rejected; shown only in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                err_q <= 1'b0;
    else if (state == IDLE) err_q <= (wr_en | rd_en) & bad;
  end

  assign addr_err = (state == DONE) && err_q;
`else
  assign bad      = 1'b0;
  assign addr_err = 1'b0;
`endif

  // State, access counter, halfword index and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      hw      <= '0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      hw      <= hw_n;
      word_q  <= word_n;
      wdata_q <= wdata_n;
    end
  end

  // Next-state logic: accept in IDLE, step through halfword accesses, 1-cycle DONE.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    hw_n    = hw;
    word_n  = word_q;
    wdata_n = wdata_q;
    cap_en  = 1'b0;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en | rd_en) begin
          acc_n  = '0;
          hw_n   = '0;
          word_n = WORD_AW'((address - BASE_ADDR) >> 2);
          if (wr_en) wdata_n = wdata;
          if (bad) begin
            state_n = DONE;
            clr     = !wr_en;
          end else begin
            state_n = wr_en ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (acc_last) begin
          acc_n = '0;
          if (hw[0]) state_n = DONE;
          else       hw_n    = hw + 2'd1;
        end else begin
          acc_n = acc + ACC_W'(1);
        end
      end
      READ: begin
        cap_en = acc_last;
        if (acc_last) begin
          acc_n = '0;
          if (hw == 2'd3) state_n = DONE;
          else            hw_n    = hw + 2'd1;
        end else begin
          acc_n = acc + ACC_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // SRAM pin levels and ready derived from the current state.
  always_comb begin
    ready      = (state == DONE) || ((state == IDLE) && !(wr_en | rd_en));
    SRAM_ADDR  = '0;
    SRAM_WE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    drive_next = (state_n == WRITE);
    dout       = hw[0] ? wdata_q[31:16] : wdata_q[15:0];
    case (state)
      WRITE: begin
        SRAM_ADDR = {word_q, hw[0]};
        // WE rises in the last cycle so address/data hold across the edge.
        SRAM_WE_N = acc_last;
      end
      READ: begin
        // Pair base word is even, so halfword = {pw[16:1], hw}.
        SRAM_ADDR = {word_q[WORD_AW-1:1], hw};
        SRAM_OE_N = 1'b0;
      end
      default: ;
    endcase
  end

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  sram_dq_buf u_dq (
    .clk        (clk),
    .rst        (rst),
    .drive_next (drive_next),
    .dout       (dout),
    .cap_en     (cap_en),
    .cap_sel    (hw),
    .clr        (clr),
    .rdata      (rdata),
    .dq         (SRAM_DQ)
  );

endmodule
